led_step_counter: RTL and testbench
===================================

LED_STEP_COUNTER -- requirements
Module: led_step_counter

Interface
REQ-001 Parameter N_LEDS, default 8: number of LED outputs, legal range 2..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable synchronised samples required to accept a button level change, minimum 1.
REQ-003 Parameter REPEAT_DELAY, default 25000000: cycles from accepted press to first auto-repeat step; 0 disables auto-repeat.
REQ-004 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat steps, minimum 1.
REQ-005 Derived constant CNT_W = clog2(N_LEDS+1): count width.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 inc_btn  in  1  raw asynchronous increment button, 1 = pressed.
REQ-009 dec_btn  in  1  raw asynchronous decrement button, 1 = pressed.
REQ-010 bar_mode  in  1  0 = dot display, 1 = bar display; may change any cycle.
REQ-011 wrap_en  in  1  0 = saturate at range ends, 1 = wrap around.
REQ-012 leds  out  N_LEDS  LED pattern.
REQ-013 count  out  CNT_W  current position, range 0..N_LEDS.
REQ-014 at_min  out  1  high when count == 0; at_max  out  1  high when count == N_LEDS.

Function
REQ-015 Each button SHALL pass through a 2-flop synchroniser, then a debouncer whose accepted level flips only after DEBOUNCE_CYCLES consecutive samples differing from it; any agreeing sample restarts the stability counter.
REQ-016 A step event SHALL be generated on each accepted 0->1 transition (press); releases generate nothing.
REQ-017 Latency: raw input stable-high before edge 1 -> count updated at edge DEBOUNCE_CYCLES+3.
REQ-018 Per-button repeat FSM: IDLE -> (press) HOLD -> (REPEAT_DELAY cycles held) REPEAT, emitting a step on entry and every REPEAT_PERIOD cycles thereafter; accepted release returns to IDLE from any state.
REQ-019 inc step only: count+1; at N_LEDS -> 0 if wrap_en, else hold N_LEDS.
REQ-020 dec step only: count-1; at 0 -> N_LEDS if wrap_en, else hold 0.
REQ-021 inc and dec steps in the same cycle SHALL cancel; count unchanged.
REQ-022 leds SHALL be a combinational function of count and bar_mode: count 0 -> all zero; count k in dot mode -> only bit k-1 set; count k in bar mode -> bits k-1..0 set.
REQ-023 at_min/at_max SHALL be combinational from count, valid in the same cycle as count.
REQ-024 No arithmetic SHALL overflow CNT_W; wrap and saturate are explicit compares, not modulo 2^CNT_W.

Reset
REQ-025 reset high at an edge SHALL clear count to 0, all synchroniser, debouncer and repeat state to released/IDLE, and all counters to 0; hence leds = 0, at_min = 1, at_max = 0.
REQ-026 Reset SHALL take priority over all step events in the same cycle.
REQ-027 A button held through reset deassertion SHALL be re-accepted as a fresh press after full debounce latency.

Structure
REQ-028 Package led_step_pkg SHALL hold the repeat FSM state enum (IDLE, HOLD, REPEAT) and the clog2-based width helper.
REQ-029 Sub-module button_conditioner (synchroniser + debouncer + repeat FSM, step-pulse output) SHALL be instantiated once per button.

Verification (N_LEDS=8, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-030 Reset, then inc_btn high with 2-cycle glitches of 3 cycles followed by a stable press -> glitches ignored, count 0->1 exactly 7 edges after the stable level begins, leds = 00000001.
REQ-031 wrap_en=0, five inc presses, then bar_mode toggled -> count=5, dot leds = 00010000, bar leds = 00011111; further presses saturate at 8 with at_max=1.
REQ-032 wrap_en=1, count=8, one inc press -> count=0, leds=0, at_min=1; one dec press -> count=8, leds=10000000 (dot).
REQ-033 inc held 40 cycles after acceptance -> steps at acceptance, +20, +25, +30, +35: count 0->5.
REQ-034 inc and dec accepted in the same cycle -> count unchanged; reset asserted during an auto-repeat hold -> count=0, and no step occurs until the held button is re-debounced.

Source files
------------

// File: rtl/led_step_pkg.sv
// Shared types and width helper for the LED step counter.
package led_step_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // Bits needed to hold any value in 0..max_val (never less than 1).
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchroniser, debouncer and auto-repeat FSM for one raw button;
// emits a one-cycle step pulse on each accepted press and repeat tick.
module button_conditioner
    import led_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic step
);

    localparam int DB_W       = width_for(DEBOUNCE_CYCLES);
    localparam int RPT_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W      = width_for(RPT_MAX);
    localparam int DELAY_LAST = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    rpt_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             step_q, step_d;
    logic             rise, fall;

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = '0;
        rise     = 1'b0;
        fall     = 1'b0;
        // The counter only survives while every sample disagrees with the accepted level.
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                rise    = sync2_q;
                fall    = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        step_d  = 1'b0;
        if (fall) begin
            state_d = IDLE;
            tmr_d   = '0;
        end else if (rise) begin
            state_d = HOLD;
            tmr_d   = '0;
            step_d  = 1'b1;
        end else begin
            case (state_q)
                HOLD: begin
                    if (REPEAT_DELAY > 0) begin
                        if (tmr_q == TMR_W'(DELAY_LAST)) begin
                            state_d = REPEAT;
                            tmr_d   = '0;
                            step_d  = 1'b1;
                        end else begin
                            tmr_d = tmr_q + TMR_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (tmr_q == TMR_W'(REPEAT_PERIOD - 1)) begin
                        tmr_d  = '0;
                        step_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                default: tmr_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
            state_q  <= IDLE;
            tmr_q    <= '0;
            step_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            step_q   <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/led_step_counter.sv
// Two-button up/down position counter driving a dot or bar LED display,
// with debounced inputs, auto-repeat and selectable wrap/saturate.
module led_step_counter
    import led_step_pkg::*;
#(
    parameter int N_LEDS          = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    localparam int CNT_W          = width_for(N_LEDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_btn,
    input  logic              dec_btn,
    input  logic              bar_mode,
    input  logic              wrap_en,
    output logic [N_LEDS-1:0] leds,
    output logic [CNT_W-1:0]  count,
    output logic              at_min,
    output logic              at_max
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_LEDS);

    logic [1:0]       btn_raw;
    logic [1:0]       step;
    logic [CNT_W-1:0] count_q, count_d;

    assign btn_raw = {dec_btn, inc_btn};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_cond (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn_raw[b]),
            .step   (step[b])
        );
    end

    // Range ends are explicit compares so the count never relies on modulo wrap.
    always_comb begin
        count_d = count_q;
        case (step)
            2'b01: begin
                if (count_q == CNT_MAX) count_d = wrap_en ? '0 : CNT_MAX;
                else                    count_d = count_q + CNT_W'(1);
            end
            2'b10: begin
                if (count_q == '0) count_d = wrap_en ? CNT_MAX : '0;
                else               count_d = count_q - CNT_W'(1);
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    always_comb begin
        leds = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            leds[i] = bar_mode ? (count_q > CNT_W'(i)) : (count_q == CNT_W'(i + 1));
        end
    end

    assign count  = count_q;
    assign at_min = (count_q == '0);
    assign at_max = (count_q == CNT_MAX);

endmodule

// File: tb/tb_led_step_counter.sv
// Scoreboard bench: stimulus schedules step edges derived from press timing,
// a reference model turns them into expected count updates, a monitor checks.
module tb_led_step_counter;

    localparam int N    = 8;
    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int CW   = 4;
    localparam int MAXC = 20000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          inc_btn = 1'b0;
    logic          dec_btn = 1'b0;
    logic          bar_mode = 1'b0;
    logic          wrap_en = 1'b0;
    logic [N-1:0]  leds;
    logic [CW-1:0] count;
    logic          at_min;
    logic          at_max;

    led_step_counter #(
        .N_LEDS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .bar_mode(bar_mode), .wrap_en(wrap_en), .leds(leds), .count(count),
        .at_min(at_min), .at_max(at_max)
    );

    always #5 clk = ~clk;

    typedef struct { int at_edge; int val; } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   mcount  = 0;
    bit   inc_at[MAXC];
    bit   dec_at[MAXC];
    exp_t exp_q[$];
    bit   mon_en = 1'b0;
    int   prev_cnt = 0;
    logic prev_bar = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] led_ref(input int k, input logic bar);
        int unsigned v;
        if (k == 0)   v = 0;
        else if (bar) v = (32'd1 << k) - 1;
        else          v = 32'd1 << (k - 1);
        return v[N-1:0];
    endfunction

    // Button raised just after edge p and held for `hold` cycles: first step lands
    // at edge p+D+3, repeats RD then every RP later while the repeat precedes release.
    task automatic sched(input bit is_dec, input int p, input int hold);
        int off;
        int e;
        off = 0;
        while (off < hold) begin
            e = p + D + 3 + off;
            if (e < MAXC) begin
                if (is_dec) dec_at[e] = 1'b1;
                else        inc_at[e] = 1'b1;
            end
            off = (off == 0) ? RD : off + RP;
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit is_dec, input int hold);
        sched(is_dec, cyc, hold);
        if (is_dec) dec_btn = 1'b1; else inc_btn = 1'b1;
        clk_n(hold);
        if (is_dec) dec_btn = 1'b0; else inc_btn = 1'b0;
        clk_n(D + 4);
    endtask

    task automatic press_both(input int hold);
        sched(1'b0, cyc, hold);
        sched(1'b1, cyc, hold);
        inc_btn = 1'b1;
        dec_btn = 1'b1;
        clk_n(hold);
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        clk_n(D + 4);
    endtask

    task automatic glitch(input bit is_dec, input int len);
        if (is_dec) dec_btn = 1'b1; else inc_btn = 1'b1;
        clk_n(len);
        if (is_dec) dec_btn = 1'b0; else inc_btn = 1'b0;
        clk_n(3);
    endtask

    // Reference model: applies scheduled steps at each edge by the counter rules.
    initial forever begin
        int prev;
        int net;
        @(posedge clk);
        cyc  = cyc + 1;
        prev = mcount;
        if (reset) begin
            mcount = 0;
        end else if (cyc < MAXC) begin
            net = int'(inc_at[cyc]) - int'(dec_at[cyc]);
            if (net > 0)      mcount = (mcount == N) ? (wrap_en ? 0 : N) : mcount + 1;
            else if (net < 0) mcount = (mcount == 0) ? (wrap_en ? N : 0) : mcount - 1;
        end
        if (mcount != prev) exp_q.push_back('{cyc, mcount});
    end

    // Monitor: every visible count change must match the next expected update.
    initial forever begin
        exp_t e;
        bit   chg;
        @(negedge clk);
        if (mon_en) begin
            chg = (int'(count) != prev_cnt);
            if (chg) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_update: count=%0d at edge %0d, nothing expected", count, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("count_value", count, e.val);
                    check("count_edge", cyc, e.at_edge);
                end
            end
            if (chg || bar_mode != prev_bar) begin
                check("leds", leds, led_ref(mcount, bar_mode));
                check("at_min", at_min, mcount == 0);
                check("at_max", at_max, mcount == N);
            end
            prev_cnt = int'(count);
            prev_bar = bar_mode;
        end
    end

    initial begin
        int p;
        int xl;
        int r;

        clk_n(3);
        check("reset_count", count, 0);
        check("reset_leds", leds, 0);
        check("reset_at_min", at_min, 1);
        check("reset_at_max", at_max, 0);
        reset    = 1'b0;
        prev_cnt = 0;
        prev_bar = bar_mode;
        mon_en   = 1'b1;

        // Short glitches are rejected; the stable press lands 7 edges later.
        repeat (3) glitch(1'b0, 2);
        press(1'b0, 10);
        check("first_press_count", count, 1);
        check("first_press_leds", leds, 8'b00000001);

        repeat (4) press(1'b0, 10);
        check("five_count", count, 5);
        check("five_dot", leds, 8'b00010000);
        bar_mode = 1'b1;
        clk_n(1);
        check("five_bar", leds, 8'b00011111);
        bar_mode = 1'b0;
        clk_n(1);
        repeat (4) press(1'b0, 10);
        check("sat_count", count, 8);
        check("sat_at_max", at_max, 1);

        wrap_en = 1'b1;
        press(1'b0, 10);
        check("wrap_up_count", count, 0);
        check("wrap_up_leds", leds, 0);
        check("wrap_up_at_min", at_min, 1);
        press(1'b1, 10);
        check("wrap_dn_count", count, 8);
        check("wrap_dn_leds", leds, 8'b10000000);

        wrap_en = 1'b0;
        reset   = 1'b1;
        clk_n(2);
        reset   = 1'b0;
        press(1'b0, 40);
        check("repeat_count", count, 5);

        press_both(30);
        check("cancel_count", count, 5);

        // Reset in the middle of an auto-repeat hold; button stays down throughout.
        p = cyc;
        r = p + 60;
        sched(1'b0, p, 60);
        inc_btn = 1'b1;
        clk_n(28);
        reset = 1'b1;
        clk_n(2);
        reset = 1'b0;
        xl = cyc;
        for (int e = xl + 1; e < MAXC; e++) inc_at[e] = 1'b0;
        sched(1'b0, xl, r - xl);
        clk_n(5);
        check("post_reset_quiet", count, 0);
        clk_n(r - cyc);
        inc_btn = 1'b0;
        clk_n(D + 4);
        check("post_reset_count", count, 3);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: press(1'b0, $urandom_range(D, 50));
                1: press(1'b1, $urandom_range(D, 50));
                2: glitch($urandom_range(0, 1) == 1, $urandom_range(1, D - 1));
                3: begin bar_mode = ~bar_mode; clk_n(1); end
                4: begin wrap_en = ~wrap_en; clk_n(1); end
                default: press_both($urandom_range(D, 30));
            endcase
        end

        clk_n(10);
        check("queue_drained", exp_q.size(), 0);
        check("final_count", count, mcount);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
